mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_resp.sv | 23 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM state, request type and address check for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    DMA_OWN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned word_num);
    return addr < word_num;
  endfunction

endpackage

// File: rtl/mem_arb_resp.sv
// rtl/mem_arb_resp.sv - per-port response register: one-cycle rvalid pulse, rdata held until next response
module mem_arb_resp
  import mem_arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        accept,
  input  logic [31:0] data,
  output logic        rvalid,
  output logic [31:0] rdata
);

  always_ff @(posedge clock) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= accept;
      if (accept) rdata <= data;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/DMA arbiter onto one memory port; define MEM_ARB_RR_EN for round-robin ties
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORD_NUM = 2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_valid,
  output logic        dma_ready,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_lock,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        range_err
);

  arb_state_t  state;
  mem_req_t    cpu_req;
  mem_req_t    dma_req;
  mem_req_t    sel_req;
  logic        pick_cpu;
  logic        pick_dma;
  logic        arb_open;
  logic        grant_cpu;
  logic        grant_dma;
  logic        transfer;
  logic        in_range;
  logic [31:0] rsp_data;
`ifdef MEM_ARB_RR_EN
  logic        rr_ptr;  // 0: CPU wins a tie, 1: DMA wins a tie
`endif

  assign cpu_req = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dma_req = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};

  always_comb begin
`ifdef MEM_ARB_RR_EN
    pick_dma = dma_valid && (!cpu_valid || rr_ptr);
`else
    pick_dma = dma_valid;
`endif
    pick_cpu = cpu_valid && !pick_dma;
  end

  // A dropped owner reopens arbitration in the same cycle, so handover costs no bubble
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    arb_open  = 1'b0;
    case (state)
      CPU_OWN: begin
        if (cpu_valid) grant_cpu = 1'b1;
        else           arb_open  = 1'b1;
      end
      DMA_OWN: begin
        if (dma_valid)      grant_dma = 1'b1;
        else if (!dma_lock) arb_open  = 1'b1;
      end
      default: arb_open = 1'b1;
    endcase
    if (arb_open) begin
      grant_cpu = pick_cpu;
      grant_dma = pick_dma;
    end
    if (reset) begin
      grant_cpu = 1'b0;
      grant_dma = 1'b0;
    end
  end

  always_comb begin
    if (grant_dma)      sel_req = dma_req;
    else if (grant_cpu) sel_req = cpu_req;
    else                sel_req = '0;
  end

  assign transfer  = grant_cpu | grant_dma;
  assign in_range  = addr_in_range(sel_req.addr, WORD_NUM);
  assign cpu_ready = grant_cpu;
  assign dma_ready = grant_dma;
  assign mem_we    = sel_req.we & transfer & in_range;
  assign mem_addr  = sel_req.addr;
  assign mem_wdata = sel_req.wdata;
  assign rsp_data  = (sel_req.we || !in_range) ? '0 : mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      range_err <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      range_err <= transfer && !in_range;
      if (grant_cpu)                           state <= CPU_OWN;
      else if (grant_dma)                      state <= DMA_OWN;
      else if (!(state == DMA_OWN && dma_lock)) state <= IDLE;
`ifdef MEM_ARB_RR_EN
      if (transfer) rr_ptr <= grant_cpu;
`endif
    end
  end

  mem_arb_resp u_cpu_resp (
    .clock  (clock),
    .reset  (reset),
    .accept (grant_cpu),
    .data   (rsp_data),
    .rvalid (cpu_rvalid),
    .rdata  (cpu_rdata)
  );

  mem_arb_resp u_dma_resp (
    .clock  (clock),
    .reset  (reset),
    .accept (grant_dma),
    .data   (rsp_data),
    .rvalid (dma_rvalid),
    .rdata  (dma_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (directed scenarios plus randomized reference model)
module tb_mem_arbiter;

  localparam int unsigned WORDS = 2048;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_valid = 1'b0;
  logic        dma_ready;
  logic        dma_we = 1'b0;
  logic [31:0] dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic        dma_lock = 1'b0;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        range_err;

  logic [31:0] mem [0:WORDS-1] = '{default: 32'h0};
  logic [31:0] ref_mem [0:WORDS-1] = '{default: 32'h0};

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.WORD_NUM(WORDS)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_valid  (dma_valid),
    .dma_ready  (dma_ready),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_lock   (dma_lock),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .range_err  (range_err)
  );

  always #5 clock = ~clock;

  // Out-of-range reads see garbage so a missing zeroing in the DUT is visible
  assign mem_rdata = (mem_addr < WORDS) ? mem[mem_addr[10:0]] : 32'hBAD0_BAD0;
  always @(posedge clock) if (mem_we) mem[mem_addr[10:0]] <= mem_wdata;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_cpu(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_valid = v; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d, input logic lk);
    dma_valid = v; dma_we = we; dma_addr = a; dma_wdata = d; dma_lock = lk;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'd2048 + 32'($urandom_range(0, 3));
    if (r == 1) return 32'hFFFF_FFFF;
    return 32'd100 + 32'($urandom_range(0, 15));
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    set_cpu(1'b1, 1'b1, 32'd1, 32'h11);
    set_dma(1'b1, 1'b1, 32'd2, 32'h22, 1'b0);
    #3;
    n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL rst_cpu_ready: got %b exp 0", cpu_ready); end
    n_cmp++; if (dma_ready !== 1'b0) begin n_err++; $display("FAIL rst_dma_ready: got %b exp 0", dma_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b exp 0", mem_we); end
    tick;
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_cpu_rvalid: got %b exp 0", cpu_rvalid); end
    n_cmp++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_dma_rvalid: got %b exp 0", dma_rvalid); end
    n_cmp++; if (range_err !== 1'b0) begin n_err++; $display("FAIL rst_range_err: got %b exp 0", range_err); end
    n_cmp++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL rst_cpu_rdata: got %h exp 0", cpu_rdata); end
    n_cmp++; if (dma_rdata !== 32'h0) begin n_err++; $display("FAIL rst_dma_rdata: got %h exp 0", dma_rdata); end
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #3;
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL idle_mem_addr: got %h exp 0", mem_addr); end
    tick;
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_no_cpu_resp: got %b exp 0", cpu_rvalid); end
    n_cmp++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_no_dma_resp: got %b exp 0", dma_rvalid); end
    n_cmp++; if (mem[2] !== 32'h0) begin n_err++; $display("FAIL rst_no_write: got %h exp 0", mem[2]); end
  endtask

  task automatic test_write_read;
    set_cpu(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
    #3;
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %b exp 1", cpu_ready); end
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL wr_mem_we: got %b exp 1", mem_we); end
    n_cmp++; if (mem_addr !== 32'd5) begin n_err++; $display("FAIL wr_mem_addr: got %h exp 5", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_mem_wdata: got %h exp deadbeef", mem_wdata); end
    tick;
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL wr_ack_rvalid: got %b exp 1", cpu_rvalid); end
    n_cmp++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL wr_ack_rdata: got %h exp 0", cpu_rdata); end
    set_cpu(1'b1, 1'b0, 32'd5, 32'd0);
    #3;
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rd_mem_we: got %b exp 0", mem_we); end
    tick;
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_rvalid: got %b exp 1", cpu_rvalid); end
    n_cmp++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_rdata: got %h exp deadbeef", cpu_rdata); end
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_pulse_end: got %b exp 0", cpu_rvalid); end
    n_cmp++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_hold: got %h exp deadbeef", cpu_rdata); end
  endtask

  task automatic test_priority;
    set_cpu(1'b1, 1'b0, 32'd5, 32'd0);
    set_dma(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
    #3;
    n_cmp++; if (dma_ready !== 1'b1) begin n_err++; $display("FAIL pri_dma_ready: got %b exp 1", dma_ready); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL pri_cpu_ready: got %b exp 0", cpu_ready); end
    tick;
    n_cmp++; if (dma_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pri_dma_rdata: got %h exp deadbeef", dma_rdata); end
    set_dma(1'b1, 1'b0, 32'd6, 32'd0, 1'b0);
    #3;
    n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL pri_owner_hold: got %b exp 0", cpu_ready); end
    tick;
    set_dma(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #3;
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL pri_cpu_handover: got %b exp 1", cpu_ready); end
    n_cmp++; if (dma_ready !== 1'b0) begin n_err++; $display("FAIL pri_dma_release: got %b exp 0", dma_ready); end
    tick;
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL pri_cpu_rvalid: got %b exp 1", cpu_rvalid); end
    n_cmp++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL pri_dma_rvalid: got %b exp 0", dma_rvalid); end
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    tick;
  endtask

  task automatic test_lock_burst;
    logic [31:0] beat;
    beat = 32'd0;
    set_cpu(1'b1, 1'b0, 32'd0, 32'd0);
    for (int s = 0; s < 5; s++) begin
      if (s == 2) set_dma(1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
      else        set_dma(1'b1, 1'b1, beat, 32'hA0 + beat, 1'b1);
      #3;
      n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL lock_cpu_ready slot %0d: got %b exp 0", s, cpu_ready); end
      n_cmp++; if (mem_we !== (s != 2)) begin n_err++; $display("FAIL lock_mem_we slot %0d: got %b exp %b", s, mem_we, s != 2); end
      tick;
      n_cmp++; if (dma_rvalid !== (s != 2)) begin n_err++; $display("FAIL lock_dma_rvalid slot %0d: got %b exp %b", s, dma_rvalid, s != 2); end
      if (s != 2) beat = beat + 32'd1;
    end
    set_dma(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #3;
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL lock_release_cpu: got %b exp 1", cpu_ready); end
    tick;
    n_cmp++; if (cpu_rdata !== 32'hA0) begin n_err++; $display("FAIL lock_cpu_rdata: got %h exp a0", cpu_rdata); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem[i] !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL lock_word %0d: got %h exp %h", i, mem[i], 32'hA0 + 32'(i)); end
    end
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    tick;
  endtask

  task automatic test_range;
    set_cpu(1'b1, 1'b1, 32'd2048, 32'h1234_5678);
    #3;
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL oor_ready: got %b exp 1", cpu_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL oor_mem_we: got %b exp 0", mem_we); end
    tick;
    n_cmp++; if (range_err !== 1'b1) begin n_err++; $display("FAIL oor_wr_err: got %b exp 1", range_err); end
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL oor_wr_rvalid: got %b exp 1", cpu_rvalid); end
    n_cmp++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL oor_wr_rdata: got %h exp 0", cpu_rdata); end
    set_cpu(1'b1, 1'b0, 32'd2048, 32'd0);
    tick;
    n_cmp++; if (range_err !== 1'b1) begin n_err++; $display("FAIL oor_rd_err: got %b exp 1", range_err); end
    n_cmp++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL oor_rd_rdata: got %h exp 0", cpu_rdata); end
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    n_cmp++; if (range_err !== 1'b0) begin n_err++; $display("FAIL oor_err_pulse: got %b exp 0", range_err); end
    n_cmp++; if (mem[0] !== 32'hA0) begin n_err++; $display("FAIL oor_no_side_effect: got %h exp a0", mem[0]); end
  endtask

  task automatic test_round_robin;
    logic cv;
    logic dv;
    int   exp_w;
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick;
    reset = 1'b0;
    cv = 1'b1;
    dv = 1'b1;
`ifdef MEM_ARB_RR_EN
    exp_w = 1;
`else
    exp_w = 2;
`endif
    for (int i = 0; i < 8; i++) begin
      set_cpu(cv, 1'b0, 32'(i), 32'd0);
      set_dma(dv, 1'b0, 32'(i + 8), 32'd0, 1'b0);
      #3;
      n_cmp++; if ({cpu_ready, dma_ready} !== {exp_w == 1, exp_w == 2}) begin n_err++; $display("FAIL stream_grant %0d: got %b%b exp %b%b", i, cpu_ready, dma_ready, exp_w == 1, exp_w == 2); end
      tick;
      cv = (exp_w != 1);
      dv = (exp_w != 2);
      exp_w = (exp_w == 1) ? 2 : 1;
    end
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick;
  endtask

  task automatic test_reset_in_lock;
    set_dma(1'b1, 1'b1, 32'd7, 32'h7777_0007, 1'b1);
    #3;
    n_cmp++; if (dma_ready !== 1'b1) begin n_err++; $display("FAIL rlk_dma_ready: got %b exp 1", dma_ready); end
    tick;
    n_cmp++; if (dma_rvalid !== 1'b1) begin n_err++; $display("FAIL rlk_dma_rvalid: got %b exp 1", dma_rvalid); end
    set_dma(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    set_cpu(1'b1, 1'b0, 32'd7, 32'd0);
    reset = 1'b1;
    #3;
    n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL rlk_ready_in_reset: got %b exp 0", cpu_ready); end
    tick;
    n_cmp++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL rlk_dma_rvalid_cleared: got %b exp 0", dma_rvalid); end
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rlk_cpu_rvalid_cleared: got %b exp 0", cpu_rvalid); end
    reset = 1'b0;
    #3;
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL rlk_cpu_granted: got %b exp 1", cpu_ready); end
    tick;
    n_cmp++; if (cpu_rdata !== 32'h7777_0007) begin n_err++; $display("FAIL rlk_cpu_rdata: got %h exp 77770007", cpu_rdata); end
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick;
  endtask

  // Reference: owner keeps the port while requesting (DMA also while locked); otherwise a
  // free choice is made, DMA first, or in round-robin the side that did not get the last transfer.
  task automatic test_random;
    logic        rst, cv, cwe, dv, dwe, lk, sel_we, oor, tie_dma;
    logic [31:0] ca, cd, da, dd, sel_a, sel_d, rd, e_crd, e_drd;
    int          owner, win;
`ifdef MEM_ARB_RR_EN
    logic        last_cpu;
    last_cpu = 1'b0;
`endif
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick;
    reset = 1'b0;
    owner = 0;
    lk = 1'b0;
    e_crd = 32'h0;
    e_drd = 32'h0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) lk = ~lk;
      cv = ($urandom_range(0, 3) != 0); cwe = 1'($urandom_range(0, 1)); ca = rand_addr(); cd = $urandom();
      dv = ($urandom_range(0, 3) != 0); dwe = 1'($urandom_range(0, 1)); da = rand_addr(); dd = $urandom();
      reset = rst;
      set_cpu(cv, cwe, ca, cd);
      set_dma(dv, dwe, da, dd, lk);
`ifdef MEM_ARB_RR_EN
      tie_dma = last_cpu;
`else
      tie_dma = 1'b1;
`endif
      if (rst) win = 0;
      else if (owner == 1 && cv) win = 1;
      else if (owner == 2 && dv) win = 2;
      else if (owner == 2 && lk) win = 0;
      else if (cv && dv) win = tie_dma ? 2 : 1;
      else win = cv ? 1 : (dv ? 2 : 0);
      sel_we = (win == 1) ? cwe : ((win == 2) ? dwe : 1'b0);
      sel_a  = (win == 1) ? ca : ((win == 2) ? da : 32'h0);
      sel_d  = (win == 1) ? cd : ((win == 2) ? dd : 32'h0);
      oor = (sel_a >= WORDS);
      rd = (sel_we || oor) ? 32'h0 : ref_mem[sel_a[10:0]];
      #3;
      n_cmp++; if (cpu_ready !== (win == 1)) begin n_err++; $display("FAIL rnd_cpu_ready @%0d: got %b exp %b", n, cpu_ready, win == 1); end
      n_cmp++; if (dma_ready !== (win == 2)) begin n_err++; $display("FAIL rnd_dma_ready @%0d: got %b exp %b", n, dma_ready, win == 2); end
      n_cmp++; if (mem_we !== (sel_we && !oor)) begin n_err++; $display("FAIL rnd_mem_we @%0d: got %b exp %b", n, mem_we, sel_we && !oor); end
      n_cmp++; if (mem_addr !== sel_a) begin n_err++; $display("FAIL rnd_mem_addr @%0d: got %h exp %h", n, mem_addr, sel_a); end
      n_cmp++; if (mem_wdata !== sel_d) begin n_err++; $display("FAIL rnd_mem_wdata @%0d: got %h exp %h", n, mem_wdata, sel_d); end
      if (sel_we && !oor) ref_mem[sel_a[10:0]] = sel_d;
      if (rst) begin e_crd = 32'h0; e_drd = 32'h0; end
      if (win == 1) e_crd = rd;
      if (win == 2) e_drd = rd;
      tick;
      n_cmp++; if (cpu_rvalid !== (win == 1)) begin n_err++; $display("FAIL rnd_cpu_rvalid @%0d: got %b exp %b", n, cpu_rvalid, win == 1); end
      n_cmp++; if (dma_rvalid !== (win == 2)) begin n_err++; $display("FAIL rnd_dma_rvalid @%0d: got %b exp %b", n, dma_rvalid, win == 2); end
      n_cmp++; if (cpu_rdata !== e_crd) begin n_err++; $display("FAIL rnd_cpu_rdata @%0d: got %h exp %h", n, cpu_rdata, e_crd); end
      n_cmp++; if (dma_rdata !== e_drd) begin n_err++; $display("FAIL rnd_dma_rdata @%0d: got %h exp %h", n, dma_rdata, e_drd); end
      n_cmp++; if (range_err !== (win != 0 && oor)) begin n_err++; $display("FAIL rnd_range_err @%0d: got %b exp %b", n, range_err, win != 0 && oor); end
      if (rst) owner = 0;
      else if (win != 0) owner = win;
      else if (!(owner == 2 && lk)) owner = 0;
`ifdef MEM_ARB_RR_EN
      if (rst) last_cpu = 1'b0;
      else if (win != 0) last_cpu = (win == 1);
`endif
    end
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_priority();
    test_lock_burst();
    test_range();
    test_round_robin();
    test_reset_in_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
